// File: rtl/exe_unit_w6_core.sv
// Registered sign-magnitude execution unit: subtract, compare, shift-left, bit-toggle.
// The result and the 4-bit status word {OVERFLOW, SINGLE, EVEN, ERR} are captured together.
module exe_unit_w6_core #(
    parameter int unsigned BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_out,
    output logic [3:0]      o_status
);

    localparam int unsigned M = BITS - 1;
    localparam logic [M-1:0]    SHIFT_LIM = M[M-1:0];
    localparam logic [BITS-1:0] INDEX_LIM = BITS[BITS-1:0];

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_CMP = 2'b01,
        OP_SHL = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    op_e op;
    assign op = op_e'(i_op);

    logic         sa, sb;
    logic [M-1:0] ma, mb;

    assign sa = in_a[BITS-1];
    assign sb = in_b[BITS-1];
    assign ma = in_a[M-1:0];
    assign mb = in_b[M-1:0];

    // Subtract is done directly on magnitudes: opposite signs add, equal signs
    // take the absolute difference, so |R| always fits in M+1 bits.
    logic [M:0]    sub_sum;
    logic [M-1:0]  sub_diff;
    logic [M:0]    sub_mag;
    logic          sub_neg;
    logic [BITS-1:0] sub_out;
    logic          sub_ovf;

    always_comb begin
        sub_sum  = {1'b0, ma} + {1'b0, mb};
        sub_diff = (ma >= mb) ? (ma - mb) : (mb - ma);
        if (sa != sb) begin
            sub_mag = sub_sum;
            sub_neg = sa;
        end else begin
            sub_mag = {1'b0, sub_diff};
            sub_neg = sa ? (ma > mb) : (mb > ma);
        end
        if (sub_mag == '0)
            sub_neg = 1'b0;
        sub_ovf = sub_mag[M];
        sub_out = {sub_neg, sub_mag[M-1:0]};
    end

    // Compare treats -0 as +0 by deriving "negative" only from nonzero magnitudes.
    logic neg_a, neg_b, cmp_gt;

    always_comb begin
        neg_a = sa && (ma != '0);
        neg_b = sb && (mb != '0);
        if (neg_a != neg_b)
            cmp_gt = neg_b;
        else if (neg_a)
            cmp_gt = (ma < mb);
        else
            cmp_gt = (ma > mb);
    end

    logic [2*M-1:0]  shl_wide;
    logic            shl_ovf;
    logic            shl_err;
    logic [BITS-1:0] shl_out;

    always_comb begin
        shl_wide = {{M{1'b0}}, ma} << mb;
        shl_ovf  = |shl_wide[2*M-1:M];
        shl_err  = sb || (mb >= SHIFT_LIM);
        shl_out  = {sa, shl_wide[M-1:0]};
    end

    logic [BITS-1:0] tgl_mask;
    logic [BITS-1:0] tgl_out;
    logic            tgl_err;

    always_comb begin
        tgl_mask = {{(BITS-1){1'b0}}, 1'b1} << in_b;
        tgl_out  = in_a ^ tgl_mask;
        tgl_err  = (in_b >= INDEX_LIM);
    end

    logic [BITS-1:0] res;
    logic [BITS-1:0] res_inv;
    logic            res_ovf;
    logic            res_err;
    logic [BITS-1:0] next_out;
    logic [3:0]      next_status;

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        unique case (op)
            OP_SUB: begin
                res     = sub_out;
                res_ovf = sub_ovf;
            end
            OP_CMP: begin
                res = {{(BITS-1){1'b0}}, cmp_gt};
            end
            OP_SHL: begin
                res     = shl_out;
                res_ovf = shl_ovf;
                res_err = shl_err;
            end
            OP_TGL: begin
                res     = tgl_out;
                res_err = tgl_err;
            end
            default: ;
        endcase
    end

    // SINGLE: the inverted result is a nonzero power of two.
    always_comb begin
        res_inv = ~res;
        if (res_err) begin
            next_out    = '0;
            next_status = 4'b0001;
        end else begin
            next_out    = res;
            next_status = {res_ovf,
                           (res_inv != '0) && ((res_inv & (res_inv - 1'b1)) == '0),
                           ~^res,
                           1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_out    <= '0;
            o_status <= '0;
        end else begin
            o_out    <= next_out;
            o_status <= next_status;
        end
    end

endmodule

// File: tb/tb_exe_unit_w6_core.sv
// Scoreboard bench for exe_unit_w6_core: directed vectors push expected results,
// a monitor pops one entry per clock and compares against the registered outputs.
module tb_exe_unit_w6_core;

    typedef struct {
        logic [7:0] out;
        logic [3:0] st;
        string      tag;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] i_op;
    logic [7:0] o_out;
    logic [3:0] o_status;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    exe_unit_w6_core #(.BITS(8)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .in_a     (in_a),
        .in_b     (in_b),
        .i_op     (i_op),
        .o_out    (o_out),
        .o_status (o_status)
    );

    always #5 i_clk = ~i_clk;

    task automatic apply(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic [3:0] es);
        exp_t e;
        @(negedge i_clk);
        i_op = op;
        in_a = a;
        in_b = b;
        e.out = eo;
        e.st  = es;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        checks++;
        if (o_out !== 8'h00 || o_status !== 4'h0) begin
            errors++;
            $display("FAIL %s out=%h status=%b expected out=00 status=0000", tag, o_out, o_status);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (o_out !== e.out || o_status !== e.st) begin
                    errors++;
                    $display("FAIL %s out=%h status=%b expected out=%h status=%b",
                             e.tag, o_out, o_status, e.out, e.st);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        errors++;
        $display("FAIL timeout queue=%0d", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        i_rst = 1'b0;
        i_op  = 2'b00;
        in_a  = 8'hFF;
        in_b  = 8'h01;
        #3;
        chk_zero("reset_initial");
        @(posedge i_clk);
        #1;
        chk_zero("reset_held_edge");
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk_zero("reset_release_no_edge");

        // status = {OVERFLOW, SINGLE, EVEN, ERR}
        apply("sub_m127_1",   2'b00, 8'hFF, 8'h01, 8'h80, 4'b1000);
        apply("sub_127_m1",   2'b00, 8'h7F, 8'h81, 8'h00, 4'b1010);
        apply("sub_m120_m9",  2'b00, 8'hF8, 8'h89, 8'hEF, 4'b0100);
        apply("sub_110_11",   2'b00, 8'd110, 8'd11, 8'h63, 4'b0010);
        apply("sub_91_41",    2'b00, 8'd91, 8'd41, 8'd50, 4'b0000);
        apply("sub_neg_zero", 2'b00, 8'h85, 8'h85, 8'h00, 4'b0010);
        apply("sub_mzero_pz", 2'b00, 8'h80, 8'h00, 8'h00, 4'b0010);
        apply("sub_3_5",      2'b00, 8'h03, 8'h05, 8'h82, 4'b0010);

        apply("cmp_m50_4",    2'b01, 8'hB2, 8'h04, 8'h00, 4'b0010);
        apply("cmp_eq",       2'b01, 8'd50, 8'd50, 8'h00, 4'b0010);
        apply("cmp_mz_pz",    2'b01, 8'h80, 8'h00, 8'h00, 4'b0010);
        apply("cmp_pz_mz",    2'b01, 8'h00, 8'h80, 8'h00, 4'b0010);
        apply("cmp_90_40",    2'b01, 8'd90, 8'd40, 8'h01, 4'b0000);
        apply("cmp_m90_40",   2'b01, 8'hDA, 8'd40, 8'h00, 4'b0010);
        apply("cmp_m3_m5",    2'b01, 8'h83, 8'h85, 8'h01, 4'b0000);

        apply("shl_neg_b",    2'b10, 8'hC1, 8'h81, 8'h00, 4'b0001);
        apply("shl_9_1",      2'b10, 8'h09, 8'h01, 8'h12, 4'b0010);
        apply("shl_ff_1",     2'b10, 8'hFF, 8'h01, 8'hFE, 4'b1100);
        apply("shl_6_5",      2'b10, 8'h06, 8'h05, 8'h40, 4'b1000);
        apply("shl_81_2",     2'b10, 8'h81, 8'h02, 8'h84, 4'b0010);
        apply("shl_amt_7",    2'b10, 8'h01, 8'h07, 8'h00, 4'b0001);
        apply("shl_amt_6",    2'b10, 8'h01, 8'h06, 8'h40, 4'b0000);

        apply("tgl_idx_81",   2'b11, 8'h00, 8'h81, 8'h00, 4'b0001);
        apply("tgl_idx_70",   2'b11, 8'h00, 8'h70, 8'h00, 4'b0001);
        apply("tgl_idx_8",    2'b11, 8'h00, 8'h08, 8'h00, 4'b0001);
        apply("tgl_b0_0",     2'b11, 8'hB0, 8'h00, 8'hB1, 4'b0010);
        apply("tgl_fc_1",     2'b11, 8'hFC, 8'h01, 8'hFE, 4'b0100);
        apply("tgl_66_2",     2'b11, 8'h66, 8'h02, 8'h62, 4'b0000);
        apply("tgl_00_7",     2'b11, 8'h00, 8'h07, 8'h80, 4'b0000);
        apply("tgl_7f_7",     2'b11, 8'h7F, 8'h07, 8'hFF, 4'b0010);
        apply("tgl_66_3",     2'b11, 8'h66, 8'h03, 8'h6E, 4'b0000);

        // Mid-stream reset between edges, held across an edge, then released.
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        #1;
        chk_zero("reset_async_assert");
        @(negedge i_clk);
        i_op = 2'b10;
        in_a = 8'h09;
        in_b = 8'h01;
        @(posedge i_clk);
        #1;
        chk_zero("reset_hold_over_edge");
        @(negedge i_clk);
        #2;
        begin
            exp_t e;
            e.out = 8'h12;
            e.st  = 4'b0010;
            e.tag = "reset_first_edge";
            i_rst = 1'b1;
            q.push_back(e);
        end
        #1;
        chk_zero("reset_release_hold");

        apply("post_sub_91_41", 2'b00, 8'd91, 8'd41, 8'd50, 4'b0000);

        repeat (3) @(negedge i_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
